// File: rtl/unidade_busca_if.sv
// Fetch-stage bus: instruction-memory address/data plus the decode-side
// valid/ready handshake and control inputs (branch, halt).
interface unidade_busca_if #(
    parameter int LARGURA_END   = 8,
    parameter int LARGURA_INSTR = 8
);
    logic [LARGURA_END-1:0]   endereco;
    logic [LARGURA_INSTR-1:0] instrucao;
    logic [LARGURA_INSTR-1:0] instrucao_reg;
    logic [LARGURA_END-1:0]   pc_instr;
    logic                     valida;
    logic                     pronto;
    logic                     desvio;
    logic [LARGURA_END-1:0]   alvo;
    logic                     parar;
    logic                     parado;
    logic [15:0]              contador_instr;

    // master: the fetch unit itself
    modport master (
        output endereco, instrucao_reg, pc_instr, valida, parado, contador_instr,
        input  instrucao, pronto, desvio, alvo, parar
    );

    // slave: memory + decode stage + control environment
    modport slave (
        input  endereco, instrucao_reg, pc_instr, valida, parado, contador_instr,
        output instrucao, pronto, desvio, alvo, parar
    );
endinterface

// File: rtl/unidade_busca.sv
// Instruction-fetch stage: issues addresses to a negedge-read instruction
// memory, registers the returned word and hands it to decode via valida/pronto.
module unidade_busca #(
    parameter int LARGURA_END   = 8,
    parameter int LARGURA_INSTR = 8,
    parameter int END_INICIAL   = 0
) (
    input  logic              clock,
    input  logic              reset,
    unidade_busca_if.master   bus
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } estado_t;

    localparam logic [LARGURA_END-1:0] END_RESET = LARGURA_END'(END_INICIAL);
    localparam logic [15:0]            CNT_MAX   = 16'hFFFF;

    estado_t                  estado;
    logic [LARGURA_END-1:0]   endereco;
    logic [LARGURA_INSTR-1:0] instrucao_reg;
    logic [LARGURA_END-1:0]   pc_instr;
    logic                     valida;
    logic                     parado;
    logic [15:0]              contador_instr;

    // Advance when the register is empty or its word is being consumed.
    logic avanca;
    assign avanca = (estado == RUN) && !bus.desvio && !bus.parar && (!valida || bus.pronto);

    logic aceita;
    assign aceita = (estado == RUN) && valida && bus.pronto;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order in this block.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado         <= RUN;
            endereco       <= END_RESET;
            instrucao_reg  <= '0;
            pc_instr       <= '0;
            valida         <= 1'b0;
            parado         <= 1'b0;
            contador_instr <= '0;
        end else begin
            // A consumed instruction counts even when a branch or halt lands on the same edge.
            if (aceita && contador_instr != CNT_MAX)
                contador_instr <= contador_instr + 16'd1;

            case (estado)
                RUN: begin
                    if (bus.parar) begin
                        estado <= HALT;
                        parado <= 1'b1;
                        valida <= 1'b0;
                    end else if (bus.desvio) begin
                        // Word already read from the old address is dropped.
                        endereco <= bus.alvo;
                        valida   <= 1'b0;
                    end else if (avanca) begin
                        instrucao_reg <= bus.instrucao;
                        pc_instr      <= endereco;
                        valida        <= 1'b1;
                        endereco      <= endereco + 1'b1;
                    end
                end
                HALT: begin
                    // Frozen until reset.
                end
                default: estado <= HALT;
            endcase
        end
    end

    assign bus.endereco       = endereco;
    assign bus.instrucao_reg  = instrucao_reg;
    assign bus.pc_instr       = pc_instr;
    assign bus.valida         = valida;
    assign bus.parado         = parado;
    assign bus.contador_instr = contador_instr;

endmodule

// File: tb/tb_unidade_busca.sv
// Bench for unidade_busca: directed vector table, counter saturation run and
// randomized traffic checked against a behavioural fetch model.
module tb_unidade_busca;

    logic clock;
    logic reset;

    unidade_busca_if #(.LARGURA_END(8), .LARGURA_INSTR(8)) bus ();

    unidade_busca #(
        .LARGURA_END  (8),
        .LARGURA_INSTR(8),
        .END_INICIAL  (0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Instruction memory: read-only, returns MEM[endereco] at every negedge.
    logic [7:0] mem [256];
    always @(negedge clock) bus.instrucao = mem[bus.endereco];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what decode should see, derived from the fetch rules.
    int  m_end, m_ir, m_pc, m_cnt;
    bit  m_val, m_halt;

    task automatic model_step();
        if (reset) begin
            m_end = 0; m_ir = 0; m_pc = 0; m_val = 0; m_halt = 0; m_cnt = 0;
        end else if (!m_halt) begin
            if (m_val && bus.pronto && m_cnt < 65535) m_cnt = m_cnt + 1;
            if (bus.parar) begin
                m_halt = 1; m_val = 0;
            end else if (bus.desvio) begin
                m_end = int'(bus.alvo); m_val = 0;
            end else if (!m_val || bus.pronto) begin
                m_ir  = int'(mem[m_end]);
                m_pc  = m_end;
                m_val = 1;
                m_end = (m_end + 1) % 256;
            end
        end
    endtask

    task automatic drive(input bit rst, input bit pr, input bit de, input int al, input bit pa);
        reset      = rst;
        bus.pronto = pr;
        bus.desvio = de;
        bus.alvo   = 8'(al);
        bus.parar  = pa;
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".endereco"},       int'(bus.endereco),       m_end);
        check({tag, ".instrucao_reg"},  int'(bus.instrucao_reg),  m_ir);
        check({tag, ".pc_instr"},       int'(bus.pc_instr),       m_pc);
        check({tag, ".valida"},         int'(bus.valida),         int'(m_val));
        check({tag, ".parado"},         int'(bus.parado),         int'(m_halt));
        check({tag, ".contador_instr"}, int'(bus.contador_instr), m_cnt);
    endtask

    typedef struct {
        bit         rst, pronto, desvio, parar;
        int         alvo;
        logic [7:0] ir, pc, endr;
        bit         val, parado;
        logic [15:0] cnt;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    initial begin
        reset = 1'b1; bus.pronto = 0; bus.desvio = 0; bus.alvo = 0; bus.parar = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[0] = 8'h1C; mem[1] = 8'hE3; mem[2] = 8'h00; mem[3] = 8'hE0;
        mem[11] = 8'h1C; mem[255] = 8'hAA;

        //           rst pr de pa alvo   ir     pc     end    val par cnt
        vecs[0]  = '{1, 0, 0, 0, 0,   8'h00, 8'd0,   8'd0,   0, 0, 16'd0};
        vecs[1]  = '{1, 0, 0, 0, 0,   8'h00, 8'd0,   8'd0,   0, 0, 16'd0};
        vecs[2]  = '{0, 1, 0, 0, 0,   8'h1C, 8'd0,   8'd1,   1, 0, 16'd0};
        vecs[3]  = '{0, 1, 0, 0, 0,   8'hE3, 8'd1,   8'd2,   1, 0, 16'd1};
        vecs[4]  = '{0, 0, 0, 0, 0,   8'hE3, 8'd1,   8'd2,   1, 0, 16'd1};
        vecs[5]  = '{0, 0, 0, 0, 0,   8'hE3, 8'd1,   8'd2,   1, 0, 16'd1};
        vecs[6]  = '{0, 0, 0, 0, 0,   8'hE3, 8'd1,   8'd2,   1, 0, 16'd1};
        vecs[7]  = '{0, 1, 0, 0, 0,   8'h00, 8'd2,   8'd3,   1, 0, 16'd2};
        vecs[8]  = '{0, 1, 0, 0, 0,   8'hE0, 8'd3,   8'd4,   1, 0, 16'd3};
        vecs[9]  = '{0, 0, 1, 0, 11,  8'hE0, 8'd3,   8'd11,  0, 0, 16'd3};
        vecs[10] = '{0, 0, 0, 0, 0,   8'h1C, 8'd11,  8'd12,  1, 0, 16'd3};
        vecs[11] = '{0, 1, 0, 0, 0,   8'h56, 8'd12,  8'd13,  1, 0, 16'd4};
        vecs[12] = '{0, 1, 1, 0, 255, 8'h56, 8'd12,  8'd255, 0, 0, 16'd5};
        vecs[13] = '{0, 1, 0, 0, 0,   8'hAA, 8'd255, 8'd0,   1, 0, 16'd5};
        vecs[14] = '{0, 1, 0, 0, 0,   8'h1C, 8'd0,   8'd1,   1, 0, 16'd6};
        vecs[15] = '{0, 0, 1, 1, 34,  8'h1C, 8'd0,   8'd1,   0, 1, 16'd6};
        vecs[16] = '{0, 1, 1, 0, 99,  8'h1C, 8'd0,   8'd1,   0, 1, 16'd6};
        vecs[17] = '{0, 0, 0, 0, 0,   8'h1C, 8'd0,   8'd1,   0, 1, 16'd6};
        vecs[18] = '{1, 0, 0, 0, 0,   8'h00, 8'd0,   8'd0,   0, 0, 16'd0};
        vecs[19] = '{0, 1, 0, 0, 0,   8'h1C, 8'd0,   8'd1,   1, 0, 16'd0};
        vecs[20] = '{0, 0, 0, 0, 0,   8'h1C, 8'd0,   8'd1,   1, 0, 16'd0};
        vecs[21] = '{1, 0, 0, 0, 0,   8'h00, 8'd0,   8'd0,   0, 0, 16'd0};

        // Directed sequence: fetch, stall, branch, wrap, halt, reset mid-stall.
        #2;
        for (int i = 0; i < NVEC; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(vecs[i].rst, vecs[i].pronto, vecs[i].desvio, vecs[i].alvo, vecs[i].parar);
            check({tag, ".endereco"},       int'(bus.endereco),       int'(vecs[i].endr));
            check({tag, ".instrucao_reg"},  int'(bus.instrucao_reg),  int'(vecs[i].ir));
            check({tag, ".pc_instr"},       int'(bus.pc_instr),       int'(vecs[i].pc));
            check({tag, ".valida"},         int'(bus.valida),         int'(vecs[i].val));
            check({tag, ".parado"},         int'(bus.parado),         int'(vecs[i].parado));
            check({tag, ".contador_instr"}, int'(bus.contador_instr), int'(vecs[i].cnt));
        end

        // Counter saturation: one fill cycle, then one acceptance per edge.
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 65535; i++) drive(0, 1, 0, 0, 0);
        check("sat.before", int'(bus.contador_instr), 16'hFFFE);
        drive(0, 1, 0, 0, 0);
        check("sat.reach", int'(bus.contador_instr), 16'hFFFF);
        for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 0);
        check("sat.hold", int'(bus.contador_instr), 16'hFFFF);
        check_model("sat");

        // Randomized traffic against the model.
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        drive(1, 0, 0, 0, 0);
        check_model("rnd.reset");
        for (int c = 0; c < 3000; c++) begin
            bit rst, pr, de, pa;
            rst = ($urandom_range(0, 99) == 0);
            pr  = $urandom_range(0, 1) == 1;
            de  = ($urandom_range(0, 7) == 0);
            pa  = ($urandom_range(0, 59) == 0);
            drive(rst, pr, de, int'($urandom_range(0, 255)), pa);
            check_model($sformatf("rnd%0d", c));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
